// File: rtl/boreal_learning_sweep.sv
// Hebbian learning sweep over a synapse bank: W_new = sat(W + (eps*mu >>> ETA_SHIFT) - (W >>> DECAY_SHIFT)).
// Issues one read per cycle; a three-stage pipeline writes the updated weights back through BRAM port B.
module boreal_learning_sweep #(
  parameter int DATA_W      = 16,
  parameter int N_SYN       = 64,
  parameter int ADDR_W      = 6,
  parameter int ETA_SHIFT   = 10,
  parameter int DECAY_SHIFT = 0,
  parameter int SAT_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     enable_learning,
  input  logic signed [DATA_W-1:0] epsilon,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] w_rd_data,
  input  logic signed [DATA_W-1:0] mu_rd_data,
  output logic                     we_b,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [SAT_CNT_W-1:0]     sat_count
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = 2 * DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SYN - 1);
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  eps_q;
  logic                      en_q;
  logic                      rv, v1, ov;
  logic [ADDR_W-1:0]         a0, a1;
  logic signed [PW-1:0]      prod;
  logic signed [DATA_W-1:0]  w1;

  logic signed [PW-1:0]      delta;
  logic signed [DATA_W-1:0]  decay;
  logic signed [SW-1:0]      w_ext, d_ext, k_ext, sum;
  logic                      sat_hi, sat_lo;
  logic signed [DATA_W-1:0]  w_new;

  assign delta = prod >>> ETA_SHIFT;

  generate
    if (DECAY_SHIFT == 0) begin : g_no_decay
      assign decay = '0;
    end else begin : g_decay
      assign decay = w1 >>> DECAY_SHIFT;
    end
  endgenerate

  // Full-width sum so the clamp sees the true value, never a wrapped one.
  assign w_ext  = {{(SW-DATA_W){w1[DATA_W-1]}}, w1};
  assign d_ext  = {{(SW-PW){delta[PW-1]}}, delta};
  assign k_ext  = {{(SW-DATA_W){decay[DATA_W-1]}}, decay};
  assign sum    = w_ext + d_ext - k_ext;
  assign sat_hi = sum > MAX_V;
  assign sat_lo = sum < MIN_V;
  assign w_new  = sat_hi ? MAX_V[DATA_W-1:0] :
                  sat_lo ? MIN_V[DATA_W-1:0] : sum[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      eps_q     <= '0;
      en_q      <= 1'b0;
      rv        <= 1'b0;
      v1        <= 1'b0;
      ov        <= 1'b0;
      a0        <= '0;
      a1        <= '0;
      prod      <= '0;
      w1        <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      we_b      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_count <= '0;
    end else begin
      done <= 1'b0;
      rv   <= rd_en;
      a0   <= rd_addr;
      v1   <= rv;
      a1   <= a0;
      prod <= eps_q * mu_rd_data;
      w1   <= w_rd_data;
      ov   <= v1;
      we_b <= v1 & en_q;
      if (v1 && !abort) begin
        wr_data <= w_new;
        wr_addr <= a1;
        if ((sat_hi || sat_lo) && (sat_count != '1))
          sat_count <= sat_count + SAT_CNT_W'(1);
      end

      case (state)
        IDLE: begin
          // The done cycle is also IDLE; a start there is dropped, not queued.
          if (start && !done) begin
            state     <= ISSUE;
            eps_q     <= epsilon;
            en_q      <= enable_learning;
            sat_count <= '0;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Final write is on the port this cycle and nothing is behind it.
          if (ov && !v1 && !rv) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (abort && state != IDLE) begin
        state <= IDLE;
        rd_en <= 1'b0;
        busy  <= 1'b0;
        done  <= 1'b0;
        rv    <= 1'b0;
        v1    <= 1'b0;
        ov    <= 1'b0;
        we_b  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boreal_learning_sweep.sv
// Directed bench for boreal_learning_sweep with N_SYN=4: one instance without decay, one with DECAY_SHIFT=4.
// Expected write data per address is hand-computed and loaded before each sweep.
module tb_boreal_learning_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic enable_learning = 1'b0;
  logic signed [15:0] epsilon = '0;

  logic        rd_en, we_b, busy, done;
  logic [1:0]  rd_addr, wr_addr;
  logic signed [15:0] w_rd = '0, mu_rd = '0, wr_data;
  logic [15:0] sat_count;

  logic        rd_en_d, we_b_d, busy_d, done_d;
  logic [1:0]  rd_addr_d, wr_addr_d;
  logic signed [15:0] w_rd_d = '0, mu_rd_d = '0, wr_data_d;
  logic [15:0] sat_count_d;

  logic [15:0] w_a [4];
  logic [15:0] w_d [4];
  logic [15:0] mu_m [4];
  logic [15:0] exp_a [4];
  logic [15:0] exp_d [4];
  logic [15:0] exp_sat;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  boreal_learning_sweep #(.DATA_W(16), .N_SYN(4), .ADDR_W(2), .ETA_SHIFT(10),
                          .DECAY_SHIFT(0), .SAT_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .enable_learning(enable_learning), .epsilon(epsilon),
    .rd_en(rd_en), .rd_addr(rd_addr), .w_rd_data(w_rd), .mu_rd_data(mu_rd),
    .we_b(we_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .sat_count(sat_count)
  );

  boreal_learning_sweep #(.DATA_W(16), .N_SYN(4), .ADDR_W(2), .ETA_SHIFT(10),
                          .DECAY_SHIFT(4), .SAT_CNT_W(16)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .enable_learning(enable_learning), .epsilon(epsilon),
    .rd_en(rd_en_d), .rd_addr(rd_addr_d), .w_rd_data(w_rd_d), .mu_rd_data(mu_rd_d),
    .we_b(we_b_d), .wr_addr(wr_addr_d), .wr_data(wr_data_d),
    .busy(busy_d), .done(done_d), .sat_count(sat_count_d)
  );

  // Synchronous-read memories: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rd  <= w_a[rd_addr];
      mu_rd <= mu_m[rd_addr];
    end
    if (rd_en_d) begin
      w_rd_d  <= w_d[rd_addr_d];
      mu_rd_d <= mu_m[rd_addr_d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] w, input logic [15:0] mu, input logic [15:0] e);
    for (int i = 0; i < 4; i++) begin
      w_a[i]   = w;
      w_d[i]   = w;
      mu_m[i]  = mu;
      exp_a[i] = e;
      exp_d[i] = '0;
    end
  endtask

  task automatic sweep(input logic [15:0] eps, input logic le, input logic extra,
                       input logic ab_at_start, input logic chk_d);
    epsilon = eps;
    enable_learning = le;
    start = 1'b1;
    abort = ab_at_start;
    tick();                                   // T+1
    start = 1'b0;
    abort = 1'b0;
    epsilon = ~eps;
    enable_learning = ~le;
    chk1("rd_en_t1", rd_en, 1'b1);
    chk16("rd_addr_t1", 16'(rd_addr), 16'd0);
    chk1("busy_t1", busy, 1'b1);
    chk1("we_t1", we_b, 1'b0);
    tick();                                   // T+2
    start = extra;
    tick();                                   // T+3
    start = 1'b0;
    chk16("rd_addr_t3", 16'(rd_addr), 16'd2);
    chk1("busy_t3", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();                                 // T+4+i
      chk1("we_b", we_b, le);
      chk16("wr_addr", 16'(wr_addr), 16'(i));
      chk16("wr_data", wr_data, exp_a[i]);
      chk1("busy_w", busy, 1'b1);
      chk1("done_w", done, 1'b0);
      if (chk_d) chk16("wr_data_decay", wr_data_d, exp_d[i]);
    end
    tick();                                   // T+8
    chk1("done_t8", done, 1'b1);
    chk1("busy_t8", busy, 1'b0);
    chk1("rd_en_t8", rd_en, 1'b0);
    chk1("we_t8", we_b, 1'b0);
    chk16("sat_count", sat_count, exp_sat);
    start = extra;
    tick();                                   // T+9
    start = 1'b0;
    chk1("done_t9", done, 1'b0);
    chk1("busy_t9", busy, 1'b0);
    chk1("rd_en_t9", rd_en, 1'b0);
    chk16("sat_hold", sat_count, exp_sat);
  endtask

  initial begin
    set_mem(16'd0, 16'd0, 16'd0);
    exp_sat = '0;
    tick();
    tick();
    chk1("rst_rd_en", rd_en, 1'b0);
    chk1("rst_we_b", we_b, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk16("rst_rd_addr", 16'(rd_addr), 16'd0);
    chk16("rst_wr_addr", 16'(wr_addr), 16'd0);
    chk16("rst_wr_data", wr_data, 16'd0);
    chk16("rst_sat", sat_count, 16'd0);
    rst_n = 1'b1;
    tick();

    // Basic: 100 + (1024*1024 >>> 10) = 1124
    set_mem(16'd100, 16'd1024, 16'd1124);
    exp_sat = 16'd0;
    sweep(16'd1024, 1'b1, 1'b0, 1'b0, 1'b0);

    // Mixed mu, extra starts during busy/done, abort coincident with start
    set_mem(16'd100, 16'd1024, 16'd1124);
    mu_m[1] = 16'd2048;  exp_a[1] = 16'd2148;
    mu_m[2] = -16'sd1024; exp_a[2] = -16'sd924;
    mu_m[3] = 16'd0;     exp_a[3] = 16'd100;
    exp_sat = 16'd0;
    sweep(16'd1024, 1'b1, 1'b1, 1'b1, 1'b0);

    // Positive saturation
    set_mem(16'd32000, 16'd32767, 16'd32767);
    exp_sat = 16'd4;
    sweep(16'd32767, 1'b1, 1'b0, 1'b0, 1'b0);

    // Negative saturation
    set_mem(16'd0, 16'd32767, 16'h8000);
    exp_sat = 16'd4;
    sweep(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Floor of arithmetic shift: -1 >>> 10 = -1, so 5 -> 4
    set_mem(16'd5, 16'd1, 16'd4);
    exp_sat = 16'd0;
    sweep(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);

    // Decay: eps=0, W=+-1600, decay = W>>>4 = +-100
    set_mem(16'd1600, 16'd0, 16'd1600);
    for (int i = 0; i < 4; i++) exp_d[i] = 16'd1500;
    w_a[2] = -16'sd1600; w_d[2] = -16'sd1600; exp_a[2] = -16'sd1600; exp_d[2] = -16'sd1500;
    w_a[3] = -16'sd1600; w_d[3] = -16'sd1600; exp_a[3] = -16'sd1600; exp_d[3] = -16'sd1500;
    exp_sat = 16'd0;
    sweep(16'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk16("decay_sat", sat_count_d, 16'd0);

    // Dry run: identical timing, no writes enabled
    set_mem(16'd100, 16'd1024, 16'd1124);
    exp_sat = 16'd0;
    sweep(16'd1024, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort at T+3
    set_mem(16'd32000, 16'd32767, 16'd32767);
    epsilon = 16'd32767;
    enable_learning = 1'b1;
    start = 1'b1;
    tick();                                   // T+1
    start = 1'b0;
    tick();                                   // T+2
    tick();                                   // T+3
    abort = 1'b1;
    tick();                                   // T+4
    abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_rd_en", rd_en, 1'b0);
    chk1("abort_we", we_b, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("abort_we_after", we_b, 1'b0);
      chk1("abort_no_done", done, 1'b0);
    end

    // Reset mid-sweep
    set_mem(16'd32000, 16'd32767, 16'd32767);
    epsilon = 16'd32767;
    enable_learning = 1'b1;
    start = 1'b1;
    tick();                                   // T+1
    start = 1'b0;
    tick();
    tick();
    tick();                                   // T+4
    chk1("pre_rst_we", we_b, 1'b1);
    chk16("pre_rst_data", wr_data, 16'd32767);
    tick();                                   // T+5
    chk16("pre_rst_sat", sat_count, 16'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_we", we_b, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_rd_en", rd_en, 1'b0);
    chk16("arst_wr_data", wr_data, 16'd0);
    chk16("arst_wr_addr", 16'(wr_addr), 16'd0);
    chk16("arst_rd_addr", 16'(rd_addr), 16'd0);
    chk16("arst_sat", sat_count, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Clean sweep after reset
    set_mem(16'd100, 16'd1024, 16'd1124);
    exp_sat = 16'd0;
    sweep(16'd1024, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boreal_learning_sweep.md
Name: boreal_learning_sweep

Overview:
Parametrised Hebbian learning engine that sweeps an entire synapse bank per trigger, applying W_new = sat(W_old + ((ε·μ_i) >>> ETA_SHIFT) − (W_old >>> DECAY_SHIFT)). It sits between the inference core, which supplies the prediction error ε, and the dual-port weight BRAM. It reads μ_i from the manifold state memory and writes updated weights back via BRAM Port B. It is fully pipelined at one synapse per cycle, with start/done handshake, abort, and saturation telemetry.

Parameters:
DATA_W, 16, signed width of ε, μ and weights
N_SYN, 64, synapses per sweep (≥1)
ADDR_W, 6, address width, ≥ clog2(N_SYN)
ETA_SHIFT, 10, learning-rate right shift (0..2*DATA_W-2)
DECAY_SHIFT, 0, weight-decay shift; 0 disables decay
SAT_CNT_W, 16, saturation counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  sweep request, sampled only in IDLE
abort  in  1  synchronous sweep cancel
enable_learning  in  1  write permission, latched at start
epsilon  in  DATA_W  signed prediction error, latched at start
rd_en  out  1  read strobe to weight BRAM Port A and μ memory
rd_addr  out  ADDR_W  synapse index for both reads
w_rd_data  in  DATA_W  signed W_old, valid one cycle after rd_en
mu_rd_data  in  DATA_W  signed μ_i, valid one cycle after rd_en
we_b  out  1  BRAM Port B write enable
wr_addr  out  ADDR_W  Port B address
wr_data  out  DATA_W  signed W_new
busy  out  1  sweep in progress
done  out  1  one-cycle completion pulse
sat_count  out  SAT_CNT_W  clamped updates in current/last sweep

Behaviour:
- Reset (rst_n=0, async): FSM→IDLE. rd_en, we_b, busy, done = 0. rd_addr, wr_addr, wr_data, sat_count = 0. Pipeline valid bits cleared.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE→ISSUE when start=1 in cycle T:
  - latch epsilon and enable_learning;
  - clear sat_count.
- ISSUE (cycles T+1..T+N_SYN):
  - rd_en=1;
  - rd_addr = 0..N_SYN-1, incrementing once per cycle;
  - after issuing address N_SYN-1, go to DRAIN.
- Pipeline for address issued in cycle k:
  - S1 (k+1): read data valid. Register product = ε·μ_i (2*DATA_W signed, DSP), W_old and address.
  - S2 (k+2): delta = product >>> ETA_SHIFT (arithmetic, floor). decay = W_old >>> DECAY_SHIFT, or 0 if DECAY_SHIFT=0. sum = W_old + delta − decay, computed at 2*DATA_W+2 bits with no truncation before the clamp.
  - Clamp sum to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. Register wr_data and wr_addr. Register we_b = latched enable_learning.
  - Write outputs are therefore asserted in cycle k+3.
- Latency and timing:
  - first write at T+4;
  - last write at T+N_SYN+3;
  - one write per cycle, no bubbles.
- DRAIN: wait for pipeline empty, then in cycle T+N_SYN+4: done=1 for one cycle, return to IDLE.
- busy=1 in cycles T+1..T+N_SYN+3 inclusive.
- sat_count:
  - increments for every clamped result, including when the latched enable_learning=0;
  - holds at all-ones, no wrap;
  - holds its value after done until the next accepted start.
- Latched enable_learning=0 (dry run): identical timing, we_b stays 0, wr_data/wr_addr still update.
- start while busy or during the done cycle: ignored, not queued.
- Changes to epsilon or enable_learning mid-sweep: no effect on the sweep in progress.
- abort=1 in any non-IDLE state:
  - next cycle FSM→IDLE; rd_en, busy, we_b = 0; in-flight pipeline entries discarded;
  - no done pulse;
  - sat_count holds the value reached.
- Simultaneous abort and start in IDLE: start wins, abort ignored.
- Reset mid-sweep: immediate return to reset values. Partially updated bank is acceptable.
- N_SYN=1: single read at T+1, write at T+4, done at T+5.

Test Plan:
- Basic (N_SYN=4, defaults): ε=1024, all μ=1024, all W=100 → writes at T+4..T+7, addr 0..3, wr_data=1124, done at T+8, sat_count=0.
- Positive saturation: ε=32767, μ=32767, W=32000 → product 1073676289, delta 1048512, wr_data=32767, sat_count=4.
- Negative saturation and floor: ε=−32768, μ=32767, W=0 → wr_data=−32768. ε=−1, μ=1, W=5 → delta=−1, wr_data=4.
- Decay (DECAY_SHIFT=4): ε=0, W=1600 → wr_data=1500. ε=0, W=−1600 → wr_data=−1500.
- Dry run and abort:
  - enable_learning=0 at start → we_b never 1, done at T+8;
  - abort at T+3 → no we_b after T+4, busy=0 at T+4, no done.
- Handshake: start pulsed at T+2 and T+8 during a busy sweep → ignored. rst_n low at T+5 → all outputs 0 asynchronously. New start after reset → clean sweep from addr 0.
